// File: rtl/pipe_controller_pkg.sv
// pipe_controller_pkg: shared encodings for the pipelined ARM-subset controller (CMP_EN adds CMP decode)
package pipe_controller_pkg;
   typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11} alu_ctrl_e;
   typedef enum logic [1:0] {IMM8 = 2'b00, IMM12 = 2'b01, IMM24 = 2'b10} imm_src_e;
   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   typedef struct packed {
      logic       reg_w;
      logic       mem_w;
      logic       mem_to_reg;
      logic       pcs;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_ctrl;
      logic [1:0] flag_w;
      logic [3:0] cond;
   } ex_ctrl_t;
   typedef struct packed {
      logic reg_w;
      logic mem_w;
      logic mem_to_reg;
      logic pcs;
   } mem_ctrl_t;
   typedef struct packed {
      logic reg_w;
      logic mem_to_reg;
      logic pcs;
   } wb_ctrl_t;
endpackage

// File: rtl/pipe_controller_cond_unit.sv
// cond_unit: NZCV flags register, condition evaluation and gated flag writes for the Execute stage
module cond_unit
   import pipe_controller_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   output logic       cond_ex
);
   logic [3:0] flags_q, flags_d;
   logic n, z, c, v;
   assign {n, z, c, v} = flags_q;
   always_comb begin
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = n ~^ v;
         COND_LT: cond_ex = n ^ v;
         COND_GT: cond_ex = ~z & (n ~^ v);
         COND_LE: cond_ex = z | (n ^ v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end
   always_comb begin
      flags_d = {(flag_w[1] & cond_ex) ? alu_flags[3:2] : flags_q[3:2],
                 (flag_w[0] & cond_ex) ? alu_flags[1:0] : flags_q[1:0]};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) flags_q <= '0;
      else flags_q <= flags_d;
endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: decode plus E/M/W control pipeline; define CMP_EN to decode cmd 1010 with S=1 as CMP
module pipe_controller
   import pipe_controller_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] InstrD,
   input  logic [3:0]  ALUFlags,
   input  logic        FlushE,
   output logic [1:0]  RegSrcD,
   output logic [1:0]  ImmSrcD,
   output logic        ALUSrcE,
   output logic [1:0]  ALUControlE,
   output logic        BranchTakenE,
   output logic        MemWriteM,
   output logic        RegWriteM,
   output logic        MemtoRegE,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic        PCSrcW
);
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cmd, rd;
   logic is_cmp, dp_ok, cond_ex, unused_rn;
   ex_ctrl_t dec, ex_d, ex_q;
   mem_ctrl_t mem_d, mem_q;
   wb_ctrl_t wb_d, wb_q;
   assign op = InstrD[15:14];
   assign funct = InstrD[13:8];
   assign cmd = funct[4:1];
   assign rd = InstrD[3:0];
   assign unused_rn = ^InstrD[7:4];
`ifdef CMP_EN
   assign is_cmp = (cmd == CMD_CMP) & funct[0];
`else
   assign is_cmp = 1'b0;
`endif
   assign dp_ok = (cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR}) | is_cmp;
   always_comb begin
      dec = '0;
      dec.cond = InstrD[19:16];
      RegSrcD = 2'b00;
      ImmSrcD = IMM8;
      if (op == OP_DP) begin
         dec.alu_src = funct[5];
         dec.alu_ctrl = cmd == CMD_ADD ? ALU_ADD : cmd == CMD_AND ? ALU_AND : cmd == CMD_ORR ? ALU_ORR : ALU_SUB;
         dec.reg_w = dp_ok & ~is_cmp;
         dec.flag_w = {dp_ok & funct[0], dp_ok & funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | is_cmp)};
      end else if (op == OP_MEM) begin
         dec.alu_src = 1'b1;
         dec.reg_w = funct[0];
         dec.mem_to_reg = funct[0];
         dec.mem_w = ~funct[0];
         ImmSrcD = IMM12;
         RegSrcD = funct[0] ? 2'b00 : 2'b10;
      end else if (op == OP_BR) begin
         dec.branch = 1'b1;
         dec.alu_src = 1'b1;
         ImmSrcD = IMM24;
         RegSrcD = 2'b01;
      end
      dec.pcs = dec.branch | (dec.reg_w & (rd == 4'hF));
   end
   always_comb begin
      ex_d = FlushE ? '0 : dec;
      mem_d = '{reg_w: ex_q.reg_w & cond_ex, mem_w: ex_q.mem_w & cond_ex,
                mem_to_reg: ex_q.mem_to_reg, pcs: ex_q.pcs & cond_ex};
      wb_d = '{reg_w: mem_q.reg_w, mem_to_reg: mem_q.mem_to_reg, pcs: mem_q.pcs};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ex_q <= '0;
         mem_q <= '0;
         wb_q <= '0;
      end else begin
         ex_q <= ex_d;
         mem_q <= mem_d;
         wb_q <= wb_d;
      end
   cond_unit u_cond (
      .clk(clk),
      .reset(reset),
      .cond(ex_q.cond),
      .alu_flags(ALUFlags),
      .flag_w(ex_q.flag_w),
      .cond_ex(cond_ex)
   );
   assign ALUSrcE = ex_q.alu_src;
   assign ALUControlE = ex_q.alu_ctrl;
   assign MemtoRegE = ex_q.mem_to_reg;
   assign BranchTakenE = ex_q.branch & cond_ex;
   assign MemWriteM = mem_q.mem_w;
   assign RegWriteM = mem_q.reg_w;
   assign RegWriteW = wb_q.reg_w;
   assign MemtoRegW = wb_q.mem_to_reg;
   assign PCSrcW = wb_q.pcs;
endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller: directed plus random checks of pipe_controller against an instruction-level model
module tb_pipe_controller;
   logic clk = 1'b0;
   logic reset;
   logic [19:0] InstrD;
   logic [3:0] ALUFlags;
   logic FlushE;
   logic [1:0] RegSrcD, ImmSrcD, ALUControlE;
   logic ALUSrcE, BranchTakenE, MemWriteM, RegWriteM, MemtoRegE, RegWriteW, MemtoRegW, PCSrcW;
   int total = 0;
   int bad = 0;
`ifdef CMP_EN
   localparam bit CMP_ON = 1'b1;
`else
   localparam bit CMP_ON = 1'b0;
`endif
   localparam logic [19:0] IDLE = 20'hF0000;
   always #5 clk = ~clk;
   pipe_controller dut (
      .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlags(ALUFlags), .FlushE(FlushE),
      .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .MemtoRegE(MemtoRegE),
      .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW)
   );
   typedef struct packed {
      bit known;
      bit reg_w, mem_w, mtr, pcs, branch, alu_src;
      bit [1:0] alu, flag_w, rs, imm;
      bit [3:0] cond;
   } d_t;
   d_t e;
   bit [3:0] mm, ww;
   bit [3:0] fl;
   function automatic d_t nop();
      d_t d = '0;
      d.known = 1'b1;
      return d;
   endfunction
   function automatic d_t dec(logic [19:0] i);
      d_t d = '0;
      logic [3:0] cmd = i[12:9];
      bit s = i[8];
      bit cmp = CMP_ON && i[15:14] == 2'b00 && cmd == 4'hA && s;
      d.cond = i[19:16];
      if (i[15:14] == 2'b01) begin
         d.known = 1'b1;
         d.alu_src = 1'b1;
         d.imm = 2'b01;
         d.reg_w = s;
         d.mtr = s;
         d.mem_w = !s;
         d.rs = s ? 2'b00 : 2'b10;
      end else if (i[15:14] == 2'b10) begin
         d.known = 1'b1;
         d.branch = 1'b1;
         d.alu_src = 1'b1;
         d.imm = 2'b10;
         d.rs = 2'b01;
      end else if (i[15:14] == 2'b00 && (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12 || cmp)) begin
         d.known = 1'b1;
         d.alu_src = i[13];
         d.alu = cmd == 4 ? 2'd0 : (cmd == 2 || cmp) ? 2'd1 : cmd == 0 ? 2'd2 : 2'd3;
         d.reg_w = !cmp;
         d.flag_w = {s, s && (cmd == 4 || cmd == 2 || cmp)};
      end
      d.pcs = d.branch || (d.reg_w && i[3:0] == 4'hF);
      return d;
   endfunction
   function automatic bit pass(bit [3:0] c, bit [3:0] f);
      bit n = f[3], z = f[2], cc = f[1], v = f[0];
      bit r [16];
      r = '{z, !z, cc, !cc, n, !n, v, !v, cc && !z, !cc || z, n == v, n != v, !z && n == v, z || n != v, 1'b1, 1'b0};
      return r[c];
   endfunction
   task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc(logic [19:0] i, logic [3:0] af, logic fe);
      d_t di;
      bit ce;
      InstrD = i;
      ALUFlags = af;
      FlushE = fe;
      #1;
      di = dec(i);
      if (di.known) begin
         chk("RegSrcD", 4'(RegSrcD), 4'(di.rs));
         chk("ImmSrcD", 4'(ImmSrcD), 4'(di.imm));
      end
      if (e.known) begin
         chk("ALUSrcE", 4'(ALUSrcE), 4'(e.alu_src));
         chk("ALUControlE", 4'(ALUControlE), 4'(e.alu));
      end
      chk("MemtoRegE", 4'(MemtoRegE), 4'(e.mtr));
      chk("BranchTakenE", 4'(BranchTakenE), 4'(e.branch && pass(e.cond, fl)));
      chk("RegWriteM", 4'(RegWriteM), 4'(mm[3]));
      chk("MemWriteM", 4'(MemWriteM), 4'(mm[2]));
      chk("RegWriteW", 4'(RegWriteW), 4'(ww[3]));
      chk("MemtoRegW", 4'(MemtoRegW), 4'(ww[1]));
      chk("PCSrcW", 4'(PCSrcW), 4'(ww[0]));
      @(posedge clk);
      ce = pass(e.cond, fl);
      if (ce && e.flag_w[1]) fl[3:2] = af[3:2];
      if (ce && e.flag_w[0]) fl[1:0] = af[1:0];
      ww = mm;
      mm = {e.reg_w && ce, e.mem_w && ce, e.mtr, e.pcs && ce};
      e = fe ? nop() : dec(i);
      #1;
   endtask
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst ALUSrcE", 4'(ALUSrcE), 4'd0);
      chk("rst ALUControlE", 4'(ALUControlE), 4'd0);
      chk("rst MemtoRegE", 4'(MemtoRegE), 4'd0);
      chk("rst BranchTakenE", 4'(BranchTakenE), 4'd0);
      chk("rst MemWriteM", 4'(MemWriteM), 4'd0);
      chk("rst RegWriteM", 4'(RegWriteM), 4'd0);
      chk("rst RegWriteW", 4'(RegWriteW), 4'd0);
      chk("rst MemtoRegW", 4'(MemtoRegW), 4'd0);
      chk("rst PCSrcW", 4'(PCSrcW), 4'd0);
      e = nop();
      mm = '0;
      ww = '0;
      fl = '0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
   endtask
   function automatic logic [19:0] rand_instr();
      logic [19:0] i = 20'($urandom);
      logic [3:0] cmds [5] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA};
      int k = $urandom_range(0, 5);
      if (k < 5) i[12:9] = cmds[k];
      if ($urandom_range(0, 1) == 0) i[19:16] = 4'hE;
      if ($urandom_range(0, 3) == 0) i[3:0] = 4'hF;
      return i;
   endfunction
   initial begin
      reset = 1'b0;
      InstrD = IDLE;
      ALUFlags = '0;
      FlushE = 1'b0;
      #2;
      do_reset();
      // ADD R0,R0,#9
      cyc(20'hE2800, 4'h0, 1'b0);
      chk("add ALUSrcE", 4'(ALUSrcE), 4'd1);
      chk("add ALUControlE", 4'(ALUControlE), 4'd0);
      cyc(IDLE, 4'h0, 1'b0);
      cyc(IDLE, 4'h0, 1'b0);
      chk("add RegWriteW", 4'(RegWriteW), 4'd1);
      chk("add MemtoRegW", 4'(MemtoRegW), 4'd0);
      // SUB R0,PC,PC
      cyc(20'hE04F0, 4'h0, 1'b0);
      chk("sub ALUSrcE", 4'(ALUSrcE), 4'd0);
      chk("sub ALUControlE", 4'(ALUControlE), 4'd1);
      cyc(IDLE, 4'h0, 1'b0);
      cyc(IDLE, 4'h0, 1'b0);
      chk("sub RegWriteW", 4'(RegWriteW), 4'd1);
      chk("sub PCSrcW", 4'(PCSrcW), 4'd0);
      // SUBS then BEQ, zero-stall flag forwarding
      cyc(20'hE0500, 4'h0, 1'b0);
      cyc(20'h0A000, 4'b0100, 1'b0);
      chk("beq taken", 4'(BranchTakenE), 4'd1);
      cyc(20'hE0500, 4'h0, 1'b0);
      cyc(20'h0A000, 4'b0000, 1'b0);
      chk("beq not taken", 4'(BranchTakenE), 4'd0);
      cyc(20'h1A000, 4'b0100, 1'b0);
      chk("bne taken", 4'(BranchTakenE), 4'd1);
      // LDR / STR
      InstrD = 20'hE5901;
      #1;
      chk("ldr ImmSrcD", 4'(ImmSrcD), 4'd1);
      cyc(20'hE5901, 4'h0, 1'b0);
      chk("ldr MemtoRegE", 4'(MemtoRegE), 4'd1);
      cyc(IDLE, 4'h0, 1'b0);
      cyc(IDLE, 4'h0, 1'b0);
      chk("ldr RegWriteW", 4'(RegWriteW), 4'd1);
      chk("ldr MemtoRegW", 4'(MemtoRegW), 4'd1);
      InstrD = 20'hE5801;
      #1;
      chk("str RegSrcD", 4'(RegSrcD), 4'd2);
      cyc(20'hE5801, 4'h0, 1'b0);
      cyc(IDLE, 4'h0, 1'b0);
      chk("str MemWriteM", 4'(MemWriteM), 4'd1);
      cyc(IDLE, 4'h0, 1'b0);
      chk("str RegWriteW", 4'(RegWriteW), 4'd0);
      // flush an ADD entering Execute
      cyc(20'hE2800, 4'h0, 1'b1);
      cyc(IDLE, 4'h0, 1'b0);
      chk("flush RegWriteM", 4'(RegWriteM), 4'd0);
      cyc(IDLE, 4'h0, 1'b0);
      chk("flush RegWriteW", 4'(RegWriteW), 4'd0);
      // reset with STR in Memory
      cyc(20'hE5801, 4'h0, 1'b0);
      cyc(IDLE, 4'h0, 1'b0);
      chk("pre-reset MemWriteM", 4'(MemWriteM), 4'd1);
      do_reset();
      cyc(IDLE, 4'h0, 1'b0);
      cyc(IDLE, 4'h0, 1'b0);
      // CMP sets Z only when the CMP decode is built in
      cyc(20'hE1500, 4'h0, 1'b0);
      cyc(20'h0A000, 4'b0100, 1'b0);
      chk("cmp beq", 4'(BranchTakenE), 4'(CMP_ON));
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         else cyc(rand_instr(), 4'($urandom), $urandom_range(0, 7) == 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
